// File: rtl/sram_init_arbiter_if.sv
// rtl/sram_init_arbiter_if.sv - requester, response and SRAM port bundle for sram_init_arbiter
interface sram_init_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 112
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_wen;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              rsp0_valid;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_wen;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              rsp1_valid;

  logic [DATA_W-1:0] rsp_rdata;

  logic              sram_en;
  logic              sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  req0_valid, req0_wen, req0_addr, req0_wdata,
    input  req1_valid, req1_wen, req1_addr, req1_wdata,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata,
    output sram_en, sram_wen, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output req0_valid, req0_wen, req0_addr, req0_wdata,
    output req1_valid, req1_wen, req1_addr, req1_wdata,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata,
    input  sram_en, sram_wen, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/sram_init_arbiter.sv
// rtl/sram_init_arbiter.sv - SRAM clear sequencer plus two-way round-robin port arbiter
module sram_init_arbiter #(
  parameter int                ADDR_W     = 5,
  parameter int                DATA_W     = 112,
  parameter int                DEPTH      = 32,
  parameter logic [DATA_W-1:0] INIT_VALUE = {DATA_W{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init_req,
  output logic             init_done,
  sram_init_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] init_cnt;
  logic              rr_ptr;
  logic              gnt0;
  logic              gnt1;

  // A pending init_req blocks the grant so the clear starts on a quiet port.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == RUN && !init_req) begin
      gnt0 = bus.req0_valid && (!bus.req1_valid || !rr_ptr);
      gnt1 = bus.req1_valid && (!bus.req0_valid ||  rr_ptr);
    end
  end

  assign init_done     = (state == RUN);
  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.rsp_rdata  = bus.sram_rdata;

  always_comb begin
    bus.sram_en    = 1'b0;
    bus.sram_wen   = 1'b0;
    bus.sram_addr  = init_cnt;
    bus.sram_wdata = INIT_VALUE;
    if (state == INIT) begin
      bus.sram_en  = 1'b1;
      bus.sram_wen = 1'b1;
    end else if (gnt0) begin
      bus.sram_en    = 1'b1;
      bus.sram_wen   = bus.req0_wen;
      bus.sram_addr  = bus.req0_addr;
      bus.sram_wdata = bus.req0_wdata;
    end else if (gnt1) begin
      bus.sram_en    = 1'b1;
      bus.sram_wen   = bus.req1_wen;
      bus.sram_addr  = bus.req1_addr;
      bus.sram_wdata = bus.req1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      init_cnt       <= '0;
      rr_ptr         <= 1'b0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
    end else begin
      bus.rsp0_valid <= gnt0 && !bus.req0_wen;
      bus.rsp1_valid <= gnt1 && !bus.req1_wen;
      case (state)
        IDLE: begin
          state    <= INIT;
          init_cnt <= '0;
        end
        INIT: begin
          if (init_cnt == ADDR_W'(DEPTH - 1)) begin
            state    <= RUN;
            init_cnt <= '0;
          end else begin
            init_cnt <= init_cnt + ADDR_W'(1);
          end
        end
        RUN: begin
          if (init_req) begin
            state    <= INIT;
            init_cnt <= '0;
          end else if (gnt0) begin
            rr_ptr <= 1'b1;
          end else if (gnt1) begin
            rr_ptr <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          init_cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sram_init_arbiter.sv
// tb/tb_sram_init_arbiter.sv - scoreboard bench for sram_init_arbiter with a behavioural SRAM
module tb_sram_init_arbiter;
  localparam int AW = 5;
  localparam int DW = 112;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_req = 1'b0;
  logic init_done;
  int   checks = 0;
  int   failures = 0;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t exp_q[$];

  logic [DW-1:0] mem [32];
  localparam logic [DW-1:0] PAT_A5  = {14{8'hA5}};
  localparam logic [DW-1:0] GARBAGE = {4{28'hDEADBEE}};

  sram_init_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_init_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_req  (init_req),
    .init_done (init_done),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  // Reset scribbles the array so only the clear sequence can produce zeros.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= GARBAGE;
    end else if (bus.sram_en) begin
      if (bus.sram_wen) mem[bus.sram_addr] <= bus.sram_wdata;
      else              bus.sram_rdata     <= mem[bus.sram_addr];
    end
  end

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rsp0_valid === 1'b1 || bus.rsp1_valid === 1'b1) begin
      rsp_t e;
      check("rsp_exclusive", DW'(bus.rsp0_valid & bus.rsp1_valid), '0);
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", DW'({bus.rsp1_valid, bus.rsp0_valid}), '0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", DW'(bus.rsp1_valid), DW'(e.id));
        check("rsp_data", bus.rsp_rdata, e.data);
      end
    end
  end

  task automatic set_req(input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.req0_valid = v0; bus.req0_wen = w0; bus.req0_addr = a0; bus.req0_wdata = d0;
    bus.req1_valid = v1; bus.req1_wen = w1; bus.req1_addr = a1; bus.req1_wdata = d1;
  endtask

  task automatic op(input string nm,
                    input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                    input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                    input logic eg0, input logic eg1, input logic [DW-1:0] exp_data);
    rsp_t e;
    @(negedge clk);
    set_req(v0, w0, a0, d0, v1, w1, a1, d1);
    #1;
    check({nm, "_ready0"}, DW'(bus.req0_ready), DW'(eg0));
    check({nm, "_ready1"}, DW'(bus.req1_ready), DW'(eg1));
    check({nm, "_sram_en"}, DW'(bus.sram_en), DW'(eg0 | eg1));
    if (eg0 && !w0) begin e.id = 1'b0; e.data = exp_data; exp_q.push_back(e); end
    if (eg1 && !w1) begin e.id = 1'b1; e.data = exp_data; exp_q.push_back(e); end
  endtask

  // Walks the clear sequence; stop_at >= 0 asserts reset at that address instead of finishing.
  task automatic run_init(input int stop_at);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      check("init_en",    DW'(bus.sram_en), DW'(1));
      check("init_wen",   DW'(bus.sram_wen), DW'(1));
      check("init_addr",  DW'(bus.sram_addr), DW'(k));
      check("init_wdata", bus.sram_wdata, '0);
      check("init_ready", DW'({bus.req1_ready, bus.req0_ready}), '0);
      check("init_done_low", DW'(init_done), '0);
      if (k == 2) init_req = 1'b0;
      if (k == stop_at) begin
        rst_n = 1'b0;
        return;
      end
      if (k == 31) set_req(0, 0, '0, '0, 0, 0, '0, '0);
    end
    @(negedge clk);
    check("init_done_high", DW'(init_done), DW'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    set_req(1, 0, 5'd3, '0, 1, 0, 5'd4, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sram_en", DW'(bus.sram_en), '0);
    check("rst_ready",   DW'({bus.req1_ready, bus.req0_ready}), '0);
    check("rst_done",    DW'(init_done), '0);
    check("rst_rsp",     DW'({bus.rsp1_valid, bus.rsp0_valid}), '0);
    rst_n = 1'b1;
    run_init(-1);

    op("rd5",     1, 0, 5'd5,  '0,     0, 0, '0,    '0, 1, 0, '0);
    op("wr31",    1, 1, 5'd31, PAT_A5, 0, 0, '0,    '0, 1, 0, '0);
    op("rd31",    0, 0, '0,    '0,     1, 0, 5'd31, '0, 0, 1, PAT_A5);
    op("idle",    0, 0, '0,    '0,     0, 0, '0,    '0, 0, 0, '0);
    op("rr_a",    1, 0, 5'd31, '0,     1, 0, 5'd5,  '0, 1, 0, PAT_A5);
    op("rr_b",    1, 0, 5'd31, '0,     1, 0, 5'd5,  '0, 0, 1, '0);
    op("rr_c",    1, 0, 5'd31, '0,     1, 0, 5'd5,  '0, 1, 0, PAT_A5);
    op("rr_d",    1, 0, 5'd31, '0,     1, 0, 5'd5,  '0, 0, 1, '0);
    op("wr7",     0, 0, '0,    '0,     1, 1, 5'd7,  112'd3, 0, 1, '0);
    op("rd7",     1, 0, 5'd7,  '0,     0, 0, '0,    '0, 1, 0, 112'd3);

    @(negedge clk);
    init_req = 1'b1;
    set_req(1, 0, 5'd7, '0, 0, 0, '0, '0);
    #1;
    check("initreq_ready", DW'(bus.req0_ready), '0);
    check("initreq_en",    DW'(bus.sram_en), '0);
    run_init(-1);
    op("rd7_clr", 1, 0, 5'd7,  '0,     0, 0, '0,    '0, 1, 0, '0);

    @(negedge clk);
    set_req(0, 0, '0, '0, 1, 0, 5'd31, '0);
    rst_n = 1'b0;
    @(negedge clk);
    check("flight_rsp", DW'({bus.rsp1_valid, bus.rsp0_valid}), '0);
    check("flight_en",  DW'(bus.sram_en), '0);
    check("flight_done", DW'(init_done), '0);
    set_req(0, 0, '0, '0, 0, 0, '0, '0);
    rst_n = 1'b1;
    run_init(10);
    @(negedge clk);
    check("midinit_en",   DW'(bus.sram_en), '0);
    check("midinit_done", DW'(init_done), '0);
    rst_n = 1'b1;
    run_init(-1);
    op("rd31_clr", 1, 0, 5'd31, '0,    0, 0, '0,    '0, 1, 0, '0);
    op("tail",     0, 0, '0,    '0,    0, 0, '0,    '0, 0, 0, '0);
    @(negedge clk);
    check("scoreboard_empty", DW'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
